seg7_scan_capture: RTL and testbench

- Reads the multiplexed seven-segment drive (anode strobes `an`, segment lines `out`) that the display writers produce, and rebuilds the four displayed characters.
- Once all four digit positions have been captured, it presents them as a stable frame.
- Lets gameplay and verification logic check on-chip what the player sees, without probing the board.

---
 rtl/seg7_scan_if.sv | 22 ++
 rtl/seg7_scan_capture.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_capture.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Bus between a multiplexed seven-segment driver and the scan capture block:
// the raw anode/segment lines in, the rebuilt frame and status out.
interface seg7_scan_if;
  logic [3:0]  an;
  logic [6:0]  out;
  logic [15:0] hex;
  logic [3:0]  hex_ok;
  logic [27:0] seg_frame;
  logic        frame_valid;
  logic        scan_err;
  logic        stale;

  modport master (
    output an, out,
    input  hex, hex_ok, seg_frame, frame_valid, scan_err, stale
  );

  modport slave (
    input  an, out,
    output hex, hex_ok, seg_frame, frame_valid, scan_err, stale
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Snoops a multiplexed 4-digit seven-segment display and rebuilds the shown
// characters as a stable frame, with hex decode, scan error and staleness flags.
module seg7_scan_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_M1  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT);

  // Returns {glyph_ok, nibble} for an active-high gfedcba pattern.
  function automatic logic [4:0] decode(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h67: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [3:0]    an_s1_q, an_s2_q;
  logic [6:0]    seg_s1_q, seg_s2_q;
  logic [10:0]   prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [27:0]   shadow_q, shadow_d;
  logic [3:0]    seen_q, seen_d;
  logic          done_q, done_d;
  logic [15:0]   hex_q, hex_d;
  logic [3:0]    ok_q, ok_d;
  logic [27:0]   frame_q;
  logic          fv_q, err_q, stale_q;

  logic [10:0]   sample;
  logic          active, blank, illegal, same, capture;
  logic [1:0]    idx;

  always_comb begin
    sample = {an_s2_q, seg_s2_q};
    active = 1'b1;
    idx    = 2'd0;
    case (an_s2_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: active = 1'b0;
    endcase
    blank   = (an_s2_q == 4'hF);
    illegal = !active && !blank;
    same    = (sample == prev_q);
    // One capture per dwell: the counter moves past SETTLE-1 and saturates.
    capture = active && same && (cnt_q == SETTLE_M1);

    cnt_d = '0;
    if (active && same)
      cnt_d = (cnt_q == SETTLE_MAX) ? cnt_q : cnt_q + 1'b1;

    to_d = capture ? '0 : ((to_q == TO_MAX) ? to_q : to_q + 1'b1);

    shadow_d = shadow_q;
    seen_d   = done_q ? 4'h0 : seen_q;
    for (int i = 0; i < 4; i++) begin
      if (capture && (idx == i[1:0])) begin
        shadow_d[7*i +: 7] = ~seg_s2_q;
        seen_d[i]          = 1'b1;
      end
    end
    done_d = capture && (seen_d == 4'hF);

    hex_d = '0;
    ok_d  = '0;
    for (int i = 0; i < 4; i++)
      {ok_d[i], hex_d[4*i +: 4]} = decode(shadow_q[7*i +: 7]);
  end

  // Synchronizers idle at all-ones so the cleared state reads as a blank scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      prev_q   <= '1;
      cnt_q    <= '0;
      to_q     <= '0;
      shadow_q <= '0;
      seen_q   <= '0;
      done_q   <= 1'b0;
      hex_q    <= '0;
      ok_q     <= '0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      an_s1_q  <= bus.an;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= bus.out;
      seg_s2_q <= seg_s1_q;
      prev_q   <= sample;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
      done_q   <= done_d;
      fv_q     <= done_q;
      if (done_q) begin
        frame_q <= shadow_q;
        hex_q   <= hex_d;
        ok_q    <= ok_d;
      end
      err_q   <= err_q | illegal;
      stale_q <= (to_q >= TO_MAX);
    end
  end

  assign bus.hex         = hex_q;
  assign bus.hex_ok      = ok_q;
  assign bus.seg_frame   = frame_q;
  assign bus.frame_valid = fv_q;
  assign bus.scan_err    = err_q;
  assign bus.stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: expected frames are queued as scans are
// driven and compared when frame_valid pulses.
module tb_seg7_scan_capture;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_if bus ();
  seg7_scan_capture #(.SETTLE(4), .TIMEOUT(1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  ok;
    logic [27:0] seg;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_frames = 0;
  int nf;
  logic fv_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show(input logic [3:0] a, input logic [6:0] g, input int hold);
    bus.an  = a;
    bus.out = ~g;
    tick(hold);
    bus.an  = 4'hF;
    bus.out = 7'h7F;
    tick(2);
  endtask

  task automatic push(input logic [15:0] h, input logic [3:0] ok, input logic [27:0] s);
    frame_t f;
    f.hex = h;
    f.ok  = ok;
    f.seg = s;
    exp_q.push_back(f);
  endtask

  task automatic wait_frames();
    int b = 0;
    while (exp_q.size() != 0 && b < 40) begin
      tick(1);
      b++;
    end
    check("frame_arrival", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    frame_t f;
    if (!rst) begin
      if (bus.frame_valid) begin
        n_frames++;
        check("fv_one_cycle", 32'(fv_prev), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          f = exp_q.pop_front();
          check("hex", 32'(bus.hex), 32'(f.hex));
          check("hex_ok", 32'(bus.hex_ok), 32'(f.ok));
          check("seg_frame", 32'(bus.seg_frame), 32'(f.seg));
        end
      end
      fv_prev <= bus.frame_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    bus.an  = 4'hF;
    bus.out = 7'h7F;
    tick(3);
    check("rst_hex", 32'(bus.hex), 32'd0);
    check("rst_hex_ok", 32'(bus.hex_ok), 32'd0);
    check("rst_seg_frame", 32'(bus.seg_frame), 32'd0);
    check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_scan_err", 32'(bus.scan_err), 32'd0);
    check("rst_stale", 32'(bus.stale), 32'd0);
    rst = 1'b0;
    tick(2);

    // Basic scan 1,2,3,4
    push(16'h4321, 4'hF, {7'h66, 7'h4F, 7'h5B, 7'h06});
    show(4'b1110, 7'h06, 8);
    show(4'b1101, 7'h5B, 8);
    show(4'b1011, 7'h4F, 8);
    show(4'b0111, 7'h66, 8);
    wait_frames();
    check("frames_after_t1", 32'(n_frames), 32'd1);

    // Short dwell on digit 2 must not complete the partial frame
    push(16'h7432, 4'hF, {7'h07, 7'h66, 7'h4F, 7'h5B});
    show(4'b1110, 7'h5B, 8);
    show(4'b1101, 7'h4F, 8);
    show(4'b0111, 7'h07, 8);
    show(4'b1011, 7'h7F, 3);
    tick(10);
    check("no_frame_short_dwell", 32'(n_frames), 32'd1);
    show(4'b1011, 7'h66, 8);
    wait_frames();

    // Illegal anode pattern mid-scan
    push(16'h8765, 4'hF, {7'h7F, 7'h07, 7'h7D, 7'h6D});
    show(4'b1110, 7'h6D, 8);
    show(4'b1101, 7'h7D, 8);
    check("scan_err_before", 32'(bus.scan_err), 32'd0);
    bus.an = 4'b1100;
    tick(1);
    bus.an = 4'hF;
    tick(1);
    check("scan_err_2cyc", 32'(bus.scan_err), 32'd0);
    tick(1);
    check("scan_err_3cyc", 32'(bus.scan_err), 32'd1);
    show(4'b1011, 7'h07, 8);
    show(4'b0111, 7'h7F, 8);
    wait_frames();
    check("stale_fresh", 32'(bus.stale), 32'd0);

    // Long blank -> stale, then recovery
    tick(1200);
    check("stale_set", 32'(bus.stale), 32'd1);
    check("scan_err_sticky", 32'(bus.scan_err), 32'd1);
    push(16'hDCBA, 4'hF, {7'h5E, 7'h39, 7'h7C, 7'h77});
    show(4'b1110, 7'h77, 8);
    show(4'b1101, 7'h7C, 8);
    show(4'b1011, 7'h39, 8);
    show(4'b0111, 7'h5E, 8);
    wait_frames();
    check("stale_cleared", 32'(bus.stale), 32'd0);

    // Reset discards a partial frame
    show(4'b1110, 7'h3F, 8);
    show(4'b1101, 7'h3F, 8);
    rst = 1'b1;
    #1;
    check("mid_rst_hex", 32'(bus.hex), 32'd0);
    check("mid_rst_hex_ok", 32'(bus.hex_ok), 32'd0);
    check("mid_rst_seg_frame", 32'(bus.seg_frame), 32'd0);
    check("mid_rst_scan_err", 32'(bus.scan_err), 32'd0);
    check("mid_rst_stale", 32'(bus.stale), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
    nf = n_frames;
    show(4'b1011, 7'h71, 8);
    show(4'b0111, 7'h3F, 8);
    show(4'b1110, 7'h6F, 8);
    tick(10);
    check("no_frame_after_rst", 32'(n_frames), 32'(nf));
    push(16'h0FE9, 4'hF, {7'h3F, 7'h71, 7'h79, 7'h6F});
    show(4'b1101, 7'h79, 8);
    wait_frames();

    // Non-hex glyphs
    push(16'h0201, 4'b0101, {7'h49, 7'h5B, 7'h00, 7'h06});
    show(4'b1110, 7'h06, 8);
    show(4'b1101, 7'h00, 8);
    show(4'b1011, 7'h5B, 8);
    show(4'b0111, 7'h49, 8);
    wait_frames();
    check("scan_err_clean", 32'(bus.scan_err), 32'd0);
    check("frames_total", 32'(n_frames), 32'(nf + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
